// File: rtl/player_pkg.sv
// Shared types and helpers for the multi-lane note player: coordinate width,
// luma arithmetic and the strum state encoding.
package player_pkg;

  localparam int COORD_W_DEF = 12;
  localparam int LUMA_W      = 8;
  localparam int LUMA_SUM_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STRUM = 2'd1,
    GAP   = 2'd2
  } strum_state_t;

  // (R + 2G + B) / 4; the 10-bit sum cannot overflow for 8-bit channels.
  function automatic logic [LUMA_W-1:0] luma(input logic [23:0] rgb);
    logic [LUMA_SUM_W-1:0] sum;
    sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
    return sum[LUMA_SUM_W-1:2];
  endfunction

endpackage

// File: rtl/player_lane_filter.sv
// One note lane: matches the lane's screen coordinate, latches a hit within the
// frame and runs the consecutive-frame saturating counter behind the fret.
module player_lane_filter
  import player_pkg::*;
#(
  parameter int COORD_W       = COORD_W_DEF,
  parameter int FILTER_FRAMES = 3
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               pix_valid_i,
  input  logic               luma_hit_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] lane_x_i,
  input  logic [COORD_W-1:0] lane_y_i,
  input  logic               commit_i,
  input  logic               discard_i,
  input  logic               mask_i,
  output logic               fret_raw_o,
  output logic               onset_o
);

  localparam int CNT_W = 4;

  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fret_q, fret_d;
  logic             hit_now, frame_hit;

  always_comb begin
    hit_now   = pix_valid_i & luma_hit_i & (x_i == lane_x_i) & (y_i == lane_y_i);
    // A pixel landing in the commit cycle still belongs to the closing frame.
    frame_hit = hit_q | hit_now;
    hit_d     = frame_hit;
    cnt_d     = cnt_q;
    if (commit_i || discard_i) hit_d = 1'b0;
    if (commit_i) begin
      if (!mask_i || !frame_hit)                 cnt_d = '0;
      else if (cnt_q != CNT_W'(FILTER_FRAMES))   cnt_d = cnt_q + 1'b1;
    end
  end

  assign fret_d = (cnt_q == CNT_W'(FILTER_FRAMES));

  always_ff @(posedge clk) begin
    if (srst) begin
      hit_q  <= 1'b0;
      cnt_q  <= '0;
      fret_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
      fret_q <= fret_d;
    end
  end

  assign fret_raw_o = fret_q;
  assign onset_o    = fret_d & ~fret_q;

endmodule

// File: rtl/player_multilane.sv
// Multi-lane note detector: samples one pixel per lane each frame, debounces
// the hits into frets and emits frame-timed strum pulses on note onsets.
module player_multilane
  import player_pkg::*;
#(
  parameter int NUM_LANES     = 5,
  parameter int COORD_W       = COORD_W_DEF,
  parameter int LUMA_THRESH   = 128,
  parameter int FILTER_FRAMES = 3,
  parameter int STRUM_W       = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             Enable,
  input  logic                             HSync,
  input  logic                             VSync,
  input  logic                             VDE,
  input  logic [23:0]                      RGB,
  input  logic [NUM_LANES*2*COORD_W-1:0]   LanePos,
  input  logic [NUM_LANES-1:0]             LaneMask,
  input  logic [STRUM_W-1:0]               StrumTime,
  output logic [NUM_LANES-1:0]             Frets,
  output logic                             Strum,
  output logic [NUM_LANES+2:0]             Status
);

  logic               hs0_q, vs0_q, de0_q, hs1_q, vs1_q, de1_q;
  logic [23:0]        rgb0_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               synced_q, commit_q;
  logic               vs_edge, hs_edge, de_fall, commit, discard, luma_hit;
  strum_state_t       state_q, state_d;
  logic [STRUM_W-1:0] frames_q, frames_d;
  logic               pending_q, pending_d;
  logic [NUM_LANES-1:0] frets_raw, onset;
  logic               strum_raw, onset_any;

  assign vs_edge  = vs0_q & ~vs1_q;
  assign hs_edge  = hs0_q & ~hs1_q;
  assign de_fall  = ~de0_q & de1_q;
  assign commit   = vs_edge & synced_q;
  assign discard  = vs_edge & ~synced_q;
  assign luma_hit = (luma(rgb0_q) >= LUMA_W'(LUMA_THRESH));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hs_edge)                   x_d = '0;
    else if (de0_q && x_q != '1)   x_d = x_q + 1'b1;
    if (vs_edge)                   y_d = '0;
    else if (de_fall && y_q != '1) y_d = y_q + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      player_lane_filter #(
        .COORD_W      (COORD_W),
        .FILTER_FRAMES(FILTER_FRAMES)
      ) u_lane (
        .clk        (CLK),
        .srst       (RST),
        .pix_valid_i(de0_q),
        .luma_hit_i (luma_hit),
        .x_i        (x_q),
        .y_i        (y_q),
        .lane_x_i   (LanePos[gi*2*COORD_W+COORD_W +: COORD_W]),
        .lane_y_i   (LanePos[gi*2*COORD_W +: COORD_W]),
        .commit_i   (commit),
        .discard_i  (discard),
        .mask_i     (LaneMask[gi]),
        .fret_raw_o (frets_raw[gi]),
        .onset_o    (onset[gi])
      );
    end
  endgenerate

  // The FSM steps one cycle after the commit, when the registered frets update.
  assign onset_any = |onset;

  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    pending_d = pending_q;
    if (commit_q) begin
      case (state_q)
        IDLE: begin
          if (onset_any && StrumTime != '0) begin
            state_d  = STRUM;
            frames_d = StrumTime;
          end
        end
        STRUM: begin
          if (onset_any) pending_d = 1'b1;
          if (frames_q == STRUM_W'(1)) state_d  = GAP;
          else                         frames_d = frames_q - 1'b1;
        end
        GAP: begin
          pending_d = 1'b0;
          if ((pending_q || onset_any) && StrumTime != '0) begin
            state_d  = STRUM;
            frames_d = StrumTime;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs0_q <= 1'b0; vs0_q <= 1'b0; de0_q <= 1'b0; rgb0_q <= '0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
      x_q <= '0; y_q <= '0;
      synced_q <= 1'b0; commit_q <= 1'b0;
      state_q <= IDLE; frames_q <= '0; pending_q <= 1'b0;
    end else begin
      hs0_q <= HSync; vs0_q <= VSync; de0_q <= VDE; rgb0_q <= RGB;
      hs1_q <= hs0_q; vs1_q <= vs0_q; de1_q <= de0_q;
      x_q <= x_d; y_q <= y_d;
      synced_q <= synced_q | vs_edge;
      commit_q <= commit;
      state_q <= state_d; frames_q <= frames_d; pending_q <= pending_d;
    end
  end

  assign strum_raw = (state_q == STRUM);
  assign Status    = {2'(state_q), strum_raw, frets_raw};
  assign Frets     = Enable ? frets_raw : '0;
  assign Strum     = Enable & strum_raw;

endmodule
